// File: rtl/decode_stage.sv
// Registered RV32I instruction decode stage with a small output FIFO and flush.
// Optional macro RV_M_EXT_EN enables decoding of the M-extension mul/mulh/div/rem.
module decode_stage #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_ctrl,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_cnt
);

  localparam int unsigned CTRL_W = 26;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned OCC_W  = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8,  ALU_AND  = 4'd9,  ALU_MUL  = 4'd10, ALU_MULH = 4'd11;
  localparam logic [3:0] ALU_DIV = 4'd12, ALU_REM  = 4'd13, ALU_PASS_B = 4'd14;

  localparam logic [2:0] WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2, WB_IMM = 3'd3;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  logic       jump;
  logic [5:0] branch;
  imm_e       imm_type;
  logic       reg_write;
  logic       alu_b_sel;
  logic       cmp_unsigned;
  logic [3:0] alu_op;
  logic [2:0] ram_read;
  logic [1:0] ram_write;
  logic [2:0] wb_sel;
  logic       is_muldiv;
  logic       legal;

  // Field decode; any path that leaves legal low yields an all-zero control word.
  always_comb begin
    jump         = 1'b0;
    branch       = '0;
    imm_type     = IMM_I;
    reg_write    = 1'b0;
    alu_b_sel    = 1'b0;
    cmp_unsigned = 1'b0;
    alu_op       = ALU_ADD;
    ram_read     = 3'd0;
    ram_write    = 2'd0;
    wb_sel       = WB_ALU;
    is_muldiv    = 1'b0;
    legal        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; imm_type = IMM_U; reg_write = 1'b1; alu_b_sel = 1'b1;
        alu_op = ALU_PASS_B; wb_sel = WB_IMM;
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm_type = IMM_U; reg_write = 1'b1; alu_b_sel = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; jump = 1'b1; imm_type = IMM_J; reg_write = 1'b1; alu_b_sel = 1'b1;
        wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'b000); jump = 1'b1; reg_write = 1'b1; alu_b_sel = 1'b1;
        wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        legal = 1'b1; imm_type = IMM_B; alu_op = ALU_SUB;
        case (funct3)
          3'b000:  branch = 6'b100000;
          3'b001:  branch = 6'b010000;
          3'b100:  branch = 6'b001000;
          3'b101:  branch = 6'b000100;
          3'b110:  begin branch = 6'b000010; cmp_unsigned = 1'b1; end
          3'b111:  begin branch = 6'b000001; cmp_unsigned = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = 1'b1; reg_write = 1'b1; alu_b_sel = 1'b1; wb_sel = WB_MEM;
        case (funct3)
          3'b000:  ram_read = 3'd1;
          3'b001:  ram_read = 3'd2;
          3'b010:  ram_read = 3'd3;
          3'b100:  ram_read = 3'd4;
          3'b101:  ram_read = 3'd5;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        legal = 1'b1; imm_type = IMM_S; alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  ram_write = 2'd1;
          3'b001:  ram_write = 2'd2;
          3'b010:  ram_write = 2'd3;
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        legal = 1'b1; reg_write = 1'b1; alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  begin alu_op = ALU_SLTU; cmp_unsigned = 1'b1; end
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          3'b001:  begin alu_op = ALU_SLL; legal = (funct7 == F7_BASE); end
          default: begin
            alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        reg_write = 1'b1;
        case (funct7)
          F7_BASE: begin
            legal = 1'b1;
            case (funct3)
              3'b000:  alu_op = ALU_ADD;
              3'b001:  alu_op = ALU_SLL;
              3'b010:  alu_op = ALU_SLT;
              3'b011:  begin alu_op = ALU_SLTU; cmp_unsigned = 1'b1; end
              3'b100:  alu_op = ALU_XOR;
              3'b101:  alu_op = ALU_SRL;
              3'b110:  alu_op = ALU_OR;
              default: alu_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              3'b000:  begin alu_op = ALU_SUB; legal = 1'b1; end
              3'b101:  begin alu_op = ALU_SRA; legal = 1'b1; end
              default: legal = 1'b0;
            endcase
          end
          F7_MULDIV: begin
`ifdef RV_M_EXT_EN
            is_muldiv = 1'b1; legal = 1'b1;
            case (funct3)
              3'b000:  alu_op = ALU_MUL;
              3'b001:  alu_op = ALU_MULH;
              3'b100:  alu_op = ALU_DIV;
              3'b110:  alu_op = ALU_REM;
              default: legal = 1'b0;
            endcase
`else
            legal = 1'b0;
`endif
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  entry_t dec_entry;
  always_comb begin
    dec_entry.ctrl    = legal ? {jump, branch, imm_type, reg_write, alu_b_sel, cmp_unsigned,
                                 alu_op, ram_read, ram_write, wb_sel, is_muldiv} : '0;
    dec_entry.illegal = !legal;
    dec_entry.instr   = in_instr;
    dec_entry.pc      = in_pc;
  end

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [OCC_W-1:0] occ, occ_n;
  entry_t           head_n;
  logic             push, pop;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Next head: a freshly written entry bypasses the array when it lands at the read slot.
  always_comb begin
    rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
    occ_n    = occ + OCC_W'(push) - OCC_W'(pop);
    head_n   = (push && (wr_ptr == rd_ptr_n)) ? dec_entry : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
      decoded_cnt <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_n;
      occ       <= occ_n;
      in_ready  <= (occ_n != OCC_W'(DEPTH));
      out_valid <= (occ_n != '0);
      if (occ_n != '0) begin
        out_ctrl    <= head_n.ctrl;
        out_instr   <= head_n.instr;
        out_pc      <= head_n.pc;
        out_illegal <= head_n.illegal;
      end
      if (pop) decoded_cnt <= decoded_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I(+M) instruction decode stage: turns a fetched instruction into the team's 26-bit control word.
- Buffers decoded entries in a parametrised FIFO with valid/ready handshakes on both sides.
- Flags illegal encodings and supports pipeline flush.
- Sits between the fetch stage and the execute stage; replaces the purely combinational decode path.

Parameters:
- PC_W, 32, width of the program counter carried alongside each instruction.
- DEPTH, 2, number of buffered decoded entries; power of two, at least 2.
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction address.
- flush  in  1  discard all buffered and incoming instructions.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  execute accepts the head entry.
- out_ctrl  out  26  decoded control word of the head entry.
- out_instr  out  32  raw instruction of the head entry.
- out_pc  out  PC_W  address of the head entry.
- out_illegal  out  1  head entry is an illegal encoding.
- decoded_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset is asynchronous and active-high. On reset: FIFO empty, out_valid=0, in_ready=1, out_ctrl=0, out_instr=0, out_pc=0, out_illegal=0, decoded_cnt=0.
- Decode key: {opcode[6:0], funct3[14:12], funct7[31:25]}, with don't-care fields per format.
- Control word layout:
  - [25] jump; [24:19] beq, bne, blt, bge, bltu, bgeu.
  - [18:16] imm_type: 0=I, 1=S, 2=B, 3=U, 4=J.
  - [15] reg_write; [14] alu_b_sel (1=imm); [13] cmp_unsigned.
  - [12:9] alu_op: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 mul, 11 mulh, 12 div, 13 rem, 14 pass_b.
  - [8:6] ram_read: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu.
  - [5:4] ram_write: 0 none, 1 sb, 2 sh, 3 sw.
  - [3:1] wb_sel: 0 alu, 1 mem, 2 pc+4, 3 imm.
  - [0] is_muldiv.
- Illegal handling: an unmatched encoding, including a wrong funct7 on shifts or OP instructions, stores ctrl=0 and illegal=1. The entry still flows downstream so execute can trap.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 at the earliest. Decode is computed on the input side and registered into the FIFO.
- Input handshake:
  - An entry is written when in_valid && in_ready && !flush.
  - in_ready is registered and equals "FIFO not full after this cycle's updates". A simultaneous push and pop on a full FIFO is therefore not allowed: in_ready is already 0.
- Output handshake:
  - An entry is popped when out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
- Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Flush is synchronous and has priority over push and pop:
  - Next cycle the FIFO is empty, out_valid=0 and in_ready=1.
  - A same-cycle input is discarded and a same-cycle pop is not counted.
- decoded_cnt increments on each output handshake and wraps at 2^CNT_W.
- Flush or reset mid-operation loses all buffered entries; there is no partial state.

Optional Feature:
- Macro: RV_M_EXT_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes as follows, all with reg_write=1, wb_sel=alu and is_muldiv=1:
  - funct3 000 → mul; 001 → mulh; 100 → div; 110 → rem.
  - Other funct3 values are illegal.
- Undefined: every funct7=0000001 OP encoding is illegal, and is_muldiv is always 0.

Test Plan:
- Reset then in_instr=0x00500093 (addi x1,x0,5), out_ready=1 → one cycle later:
  - out_valid=1, out_illegal=0, decoded_cnt=1 after the handshake.
  - reg_write=1, alu_b_sel=1, alu_op=0, imm_type=0.
- Push 0x0000A103 (lw) and then 0x00112223 (sw) with out_ready=0 → after 2 pushes in_ready=0; then release out_ready → lw (ram_read=3) emerges first, then sw (ram_write=3), and in_ready returns to 1.
- in_instr=0xFFFFFFFF → out_illegal=1 and out_ctrl=0; a following 0x00000013 (nop) passes with illegal=0.
- FIFO full, then assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, FIFO empty; decoded_cnt is unchanged.
- Stream 10 instructions with out_ready toggling every cycle → output order and PCs match input order; decoded_cnt=10.
- 0x022081B3 (mul x3,x1,x2):
  - With RV_M_EXT_EN: alu_op=10 and is_muldiv=1.
  - Without it: out_illegal=1 and out_ctrl=0.
